// File: rtl/signal_field_ctrl.sv
// signal_field_ctrl
//   Receive-side sequencer for the OFDM SIGNAL field. It gathers the serial
//   coded SIGNAL bits and hands them to the Viterbi decoder as 3-bit codewords
//   under ready/valid flow control. It then collects the decoded bits, checks
//   parity, rate and tail, and publishes RATE/LENGTH with an ok/err pulse.
//   The whole sequence can be abandoned at any point with i_abort.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous reset, active low
//   i_abort     synchronous abort, returns to IDLE on the next cycle
//   i_di        coded SIGNAL bit
//   i_di_vld    i_di valid; only honoured in IDLE and COLLECT
//   o_cw[2:0]   codeword; o_cw[2] is bit 3k, o_cw[0] is bit 3k+2
//   o_cw_vld    codeword valid
//   i_cw_rdy    decoder ready; a transfer happens when o_cw_vld & i_cw_rdy
//   i_dec_bit   decoded bit from the decoder
//   i_dec_vld   i_dec_bit valid; only honoured in DECODE
//   o_rate[3:0] {R1,R2,R3,R4}, with R1 as decoded bit 0
//   o_length    LENGTH field, decoded bits 5..16, with bit 5 as the LSB
//   o_sig_ok    1-cycle pulse: field valid, rate/length updated
//   o_sig_err   1-cycle pulse: parity, rate, tail or timeout failure
//   o_busy      high whenever the sequencer is not IDLE
module signal_field_ctrl #(
  parameter int CODED_LEN = 96,
  parameter int NUM_CW    = 32,
  parameter int DEC_LEN   = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_abort,
  input  logic        i_di,
  input  logic        i_di_vld,
  output logic [2:0]  o_cw,
  output logic        o_cw_vld,
  input  logic        i_cw_rdy,
  input  logic        i_dec_bit,
  input  logic        i_dec_vld,
  output logic [3:0]  o_rate,
  output logic [11:0] o_length,
  output logic        o_sig_ok,
  output logic        o_sig_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_EMIT,
    S_DECODE,
    S_CHECK
  } state_t;

  localparam logic [6:0] LP_LAST_BIT = 7'(CODED_LEN - 1);
  localparam logic [4:0] LP_LAST_CW  = 5'(NUM_CW - 1);
  localparam logic [4:0] LP_LAST_DEC = 5'(DEC_LEN - 1);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CODED_LEN-1:0] r_buf;
  logic [DEC_LEN-1:0]   r_dec;
  logic [6:0]           r_bit_cnt;
  logic [4:0]           r_cw_idx;
  logic [4:0]           r_dec_idx;
  logic [7:0]           r_tmo;
  logic [2:0]           r_cw;
  logic                 r_cw_vld;
  logic [3:0]           r_rate;
  logic [11:0]          r_length;
  logic                 r_sig_ok;
  logic                 r_sig_err;

  logic                 w_last_bit;
  logic                 w_hs;
  logic                 w_last_cw;
  logic                 w_last_dec;
  logic                 w_tmo_hit;
  logic                 w_ok;
  logic [6:0]           w_cw_base;

  assign w_last_bit = (r_state == S_COLLECT) && i_di_vld && (r_bit_cnt == LP_LAST_BIT);
  assign w_hs       = (r_state == S_EMIT) && r_cw_vld && i_cw_rdy;
  assign w_last_cw  = w_hs && (r_cw_idx == LP_LAST_CW);
  assign w_last_dec = (r_state == S_DECODE) && i_dec_vld && (r_dec_idx == LP_LAST_DEC);
  assign w_tmo_hit  = (r_state == S_DECODE) && !i_dec_vld && (r_tmo == LP_TMO_LAST);

  // Even parity over bits 0..17, R4 must be set, and the six tail bits must be zero.
  assign w_ok = ~(^r_dec[17:0]) && r_dec[3] && (r_dec[23:18] == 6'd0);

  // First buffer bit of the codeword after the current one. The index wraps
  // harmlessly on the last codeword because that value is never loaded.
  assign w_cw_base = {2'b00, 5'(r_cw_idx + 5'd1)} * 7'd3;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. Abort overrides every transition.
  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_di_vld) w_next = S_COLLECT;
        S_COLLECT: if (w_last_bit) w_next = S_EMIT;
        S_EMIT:    if (w_last_cw) w_next = S_DECODE;
        S_DECODE: begin
          if (w_last_dec)     w_next = S_CHECK;
          else if (w_tmo_hit) w_next = S_IDLE;
        end
        S_CHECK:   w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // State-derived outputs.
  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  // Datapath: bit buffer, codeword register, decoded bits, counters and result.
  // Each counter clears when its state is left, so no counter ever wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_buf     <= '0;
      r_dec     <= '0;
      r_bit_cnt <= '0;
      r_cw_idx  <= '0;
      r_dec_idx <= '0;
      r_tmo     <= '0;
      r_cw      <= '0;
      r_cw_vld  <= 1'b0;
      r_rate    <= '0;
      r_length  <= '0;
      r_sig_ok  <= 1'b0;
      r_sig_err <= 1'b0;
    end else begin
      r_sig_ok  <= 1'b0;
      r_sig_err <= 1'b0;
      if (i_abort) begin
        r_bit_cnt <= '0;
        r_cw_idx  <= '0;
        r_dec_idx <= '0;
        r_tmo     <= '0;
        r_cw      <= '0;
        r_cw_vld  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cw_idx  <= '0;
            r_dec_idx <= '0;
            r_tmo     <= '0;
            if (i_di_vld) begin
              r_buf[0]  <= i_di;
              r_bit_cnt <= 7'd1;
            end else begin
              r_bit_cnt <= '0;
            end
          end
          S_COLLECT: begin
            if (i_di_vld) begin
              r_buf[r_bit_cnt] <= i_di;
              if (w_last_bit) begin
                // Codeword 0 is already in the buffer, so it can be offered straight away.
                r_bit_cnt <= '0;
                r_cw_idx  <= '0;
                r_cw      <= {r_buf[0], r_buf[1], r_buf[2]};
                r_cw_vld  <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 7'd1;
              end
            end
          end
          S_EMIT: begin
            if (w_hs) begin
              if (w_last_cw) begin
                r_cw_idx <= '0;
                r_cw_vld <= 1'b0;
              end else begin
                r_cw_idx <= r_cw_idx + 5'd1;
                r_cw     <= {r_buf[w_cw_base], r_buf[w_cw_base + 7'd1], r_buf[w_cw_base + 7'd2]};
              end
            end
          end
          S_DECODE: begin
            if (i_dec_vld) begin
              r_dec[r_dec_idx] <= i_dec_bit;
              r_tmo            <= '0;
              r_dec_idx        <= w_last_dec ? 5'd0 : r_dec_idx + 5'd1;
            end else if (w_tmo_hit) begin
              r_sig_err <= 1'b1;
              r_tmo     <= '0;
              r_dec_idx <= '0;
            end else begin
              r_tmo <= r_tmo + 8'd1;
            end
          end
          S_CHECK: begin
            r_dec_idx <= '0;
            r_tmo     <= '0;
            if (w_ok) begin
              r_sig_ok <= 1'b1;
              r_rate   <= r_dec[3:0] == 4'd0 ? 4'd0 : {r_dec[0], r_dec[1], r_dec[2], r_dec[3]};
              r_length <= r_dec[16:5];
            end else begin
              r_sig_err <= 1'b1;
            end
          end
          default: begin
            r_cw_vld <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_cw      = r_cw;
  assign o_cw_vld  = r_cw_vld;
  assign o_rate    = r_rate;
  assign o_length  = r_length;
  assign o_sig_ok  = r_sig_ok;
  assign o_sig_err = r_sig_err;

endmodule

// File: tb/tb_signal_field_ctrl.sv
// tb_signal_field_ctrl
//   Self-checking bench for signal_field_ctrl. Expected codewords are queued
//   as coded bits are driven and popped on each handshake. Expected field
//   results are queued when decoded bits are driven and popped when the
//   ok/err pulse is due.
module tb_signal_field_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_abort;
  logic        i_di;
  logic        i_di_vld;
  logic [2:0]  o_cw;
  logic        o_cw_vld;
  logic        i_cw_rdy;
  logic        i_dec_bit;
  logic        i_dec_vld;
  logic [3:0]  o_rate;
  logic [11:0] o_length;
  logic        o_sig_ok;
  logic        o_sig_err;
  logic        o_busy;

  typedef struct packed {
    logic        ok;
    logic [3:0]  rate;
    logic [11:0] len;
  } res_t;

  logic [2:0] cw_q[$];
  res_t       res_q[$];
  int         passed;
  int         total;

  signal_field_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_abort   (i_abort),
    .i_di      (i_di),
    .i_di_vld  (i_di_vld),
    .o_cw      (o_cw),
    .o_cw_vld  (o_cw_vld),
    .i_cw_rdy  (i_cw_rdy),
    .i_dec_bit (i_dec_bit),
    .i_dec_vld (i_dec_vld),
    .o_rate    (o_rate),
    .o_length  (o_length),
    .o_sig_ok  (o_sig_ok),
    .o_sig_err (o_sig_err),
    .o_busy    (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Outputs are sampled 1 time unit after the active edge, and inputs change there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Builds a decoded SIGNAL field: RATE, reserved 0, LENGTH, even parity (optionally broken), and a zero tail.
  function automatic logic [23:0] make_dec(logic [3:0] rate, logic [11:0] len, bit flip);
    logic [23:0] d;
    d       = '0;
    d[0]    = rate[3];
    d[1]    = rate[2];
    d[2]    = rate[1];
    d[3]    = rate[0];
    d[16:5] = len;
    d[17]   = (^d[16:0]) ^ flip;
    return d;
  endfunction

  task automatic drive_frame(input logic [95:0] bits, input bit gaps);
    for (int i = 0; i < 96; i++) begin
      if (gaps && (i % 7) == 3) begin
        i_di_vld = 1'b0;
        i_di     = 1'($urandom());
        tick();
      end
      i_di_vld = 1'b1;
      i_di     = bits[i];
      if ((i % 3) == 2) cw_q.push_back({bits[i-2], bits[i-1], bits[i]});
      tick();
    end
    i_di_vld = 1'b0;
    i_di     = 1'b0;
    total++;
    if (o_cw_vld !== 1'b1) $display("[TB] FAIL cw_vld_rise: got %b expected 1", o_cw_vld);
    else passed++;
  endtask

  // rdy_mode 0 holds ready high; rdy_mode 1 toggles ready 1,0,0 repeatedly. abort_k >= 0 aborts when k reaches that index.
  task automatic run_emit(input int rdy_mode, input int abort_k, input bit b2b);
    int         hs;
    int         cyc;
    bit         prev_stall;
    logic [2:0] prev_cw;
    logic [2:0] exp_cw;
    hs = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_cw = '0;
    while (hs < 32 && cyc < 400) begin
      i_cw_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (prev_stall) begin
        total++;
        if (o_cw_vld !== 1'b1 || o_cw !== prev_cw)
          $display("[TB] FAIL cw_stable: got vld=%b cw=%b expected vld=1 cw=%b", o_cw_vld, o_cw, prev_cw);
        else passed++;
      end
      if (abort_k >= 0 && hs == abort_k) begin
        i_abort = 1'b1;
        tick();
        i_abort  = 1'b0;
        i_cw_rdy = 1'b0;
        total++;
        if (o_cw_vld !== 1'b0 || o_busy !== 1'b0)
          $display("[TB] FAIL abort_idle: got vld=%b busy=%b expected 0 0", o_cw_vld, o_busy);
        else passed++;
        for (int j = 0; j < 3; j++) begin
          total++;
          if (o_sig_ok !== 1'b0 || o_sig_err !== 1'b0 || o_cw_vld !== 1'b0)
            $display("[TB] FAIL abort_quiet: got ok=%b err=%b vld=%b expected 0 0 0", o_sig_ok, o_sig_err, o_cw_vld);
          else passed++;
          tick();
        end
        cw_q.delete();
        return;
      end
      if (o_cw_vld === 1'b1 && i_cw_rdy === 1'b1) begin
        exp_cw = cw_q.pop_front();
        total++;
        if (o_cw !== exp_cw) $display("[TB] FAIL cw_%0d: got %b expected %b", hs, o_cw, exp_cw);
        else passed++;
        hs++;
      end
      prev_stall = (o_cw_vld === 1'b1) && (i_cw_rdy === 1'b0);
      prev_cw    = o_cw;
      tick();
      cyc++;
    end
    i_cw_rdy = 1'b0;
    total++;
    if (hs != 32) $display("[TB] FAIL emit_count: got %0d handshakes expected 32", hs);
    else passed++;
    if (b2b) begin
      total++;
      if (cyc != 32) $display("[TB] FAIL emit_b2b_cycles: got %0d expected 32", cyc);
      else passed++;
    end
    total++;
    if (o_cw_vld !== 1'b0 || o_busy !== 1'b1)
      $display("[TB] FAIL emit_done: got vld=%b busy=%b expected 0 1", o_cw_vld, o_busy);
    else passed++;
  endtask

  task automatic run_decode(input logic [23:0] d, input bit exp_ok, input logic [3:0] exp_rate, input logic [11:0] exp_len);
    res_t exp_res;
    res_q.push_back({exp_ok, exp_rate, exp_len});
    for (int i = 0; i < 24; i++) begin
      if (i == 6) begin
        i_dec_vld = 1'b0;
        repeat (3) tick();
      end
      i_dec_vld = 1'b1;
      i_dec_bit = d[i];
      tick();
    end
    i_dec_vld = 1'b0;
    i_dec_bit = 1'b0;
    total++;
    if (o_sig_ok !== 1'b0 || o_sig_err !== 1'b0)
      $display("[TB] FAIL early_pulse: got ok=%b err=%b expected 0 0", o_sig_ok, o_sig_err);
    else passed++;
    tick();
    exp_res = res_q.pop_front();
    total++;
    if (o_sig_ok !== exp_res.ok || o_sig_err !== !exp_res.ok)
      $display("[TB] FAIL result_pulse: got ok=%b err=%b expected ok=%b err=%b", o_sig_ok, o_sig_err, exp_res.ok, !exp_res.ok);
    else passed++;
    total++;
    if (o_rate !== exp_res.rate || o_length !== exp_res.len)
      $display("[TB] FAIL rate_length: got %b/%0d expected %b/%0d", o_rate, o_length, exp_res.rate, exp_res.len);
    else passed++;
    total++;
    if (o_busy !== 1'b0) $display("[TB] FAIL busy_after_check: got %b expected 0", o_busy);
    else passed++;
    tick();
    total++;
    if (o_sig_ok !== 1'b0 || o_sig_err !== 1'b0)
      $display("[TB] FAIL pulse_width: got ok=%b err=%b expected 0 0", o_sig_ok, o_sig_err);
    else passed++;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_abort   = 1'($urandom());
      i_di      = 1'($urandom());
      i_di_vld  = 1'($urandom());
      i_cw_rdy  = 1'($urandom());
      i_dec_bit = 1'($urandom());
      i_dec_vld = 1'($urandom());
      tick();
    end
    total++;
    if ({o_cw, o_cw_vld, o_sig_ok, o_sig_err, o_busy} !== 7'd0)
      $display("[TB] FAIL reset_ctrl: got cw=%b vld=%b ok=%b err=%b busy=%b expected all 0", o_cw, o_cw_vld, o_sig_ok, o_sig_err, o_busy);
    else passed++;
    total++;
    if (o_rate !== 4'd0 || o_length !== 12'd0)
      $display("[TB] FAIL reset_fields: got %b/%0d expected 0/0", o_rate, o_length);
    else passed++;
    i_abort = 1'b0; i_di = 1'b0; i_di_vld = 1'b0; i_cw_rdy = 1'b0; i_dec_bit = 1'b0; i_dec_vld = 1'b0;
    i_rst = 1'b1;
    tick();
    total++;
    if (o_busy !== 1'b0) $display("[TB] FAIL reset_release_busy: got %b expected 0", o_busy);
    else passed++;
  endtask

  task automatic test_nominal();
    logic [95:0] bits;
    for (int i = 0; i < 96; i++) bits[i] = ((i % 3) == 0) ? 1'b0 : 1'(i % 2);
    drive_frame(bits, 1'b1);
    run_emit(0, -1, 1'b1);
    run_decode(make_dec(4'b1101, 12'd100, 1'b0), 1'b1, 4'b1101, 12'd100);
  endtask

  task automatic test_backpressure();
    logic [95:0] bits;
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b0);
    run_emit(1, -1, 1'b0);
    run_decode(make_dec(4'b1011, 12'hABC, 1'b0), 1'b1, 4'b1011, 12'hABC);
  endtask

  task automatic test_bad_field();
    logic [95:0] bits;
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b0);
    run_emit(0, -1, 1'b0);
    run_decode(make_dec(4'b1101, 12'd77, 1'b1), 1'b0, 4'b1011, 12'hABC);
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b0);
    run_emit(0, -1, 1'b0);
    run_decode(make_dec(4'b1100, 12'd55, 1'b0), 1'b0, 4'b1011, 12'hABC);
  endtask

  task automatic test_timeout();
    logic [95:0] bits;
    int          n;
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b0);
    run_emit(0, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      i_dec_vld = 1'b1;
      i_dec_bit = 1'($urandom());
      tick();
    end
    i_dec_vld = 1'b0;
    n = 0;
    while (o_sig_err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (n != 255) $display("[TB] FAIL timeout_cycles: got %0d expected 255", n);
    else passed++;
    total++;
    if (o_busy !== 1'b0 || o_sig_ok !== 1'b0)
      $display("[TB] FAIL timeout_idle: got busy=%b ok=%b expected 0 0", o_busy, o_sig_ok);
    else passed++;
    total++;
    if (o_rate !== 4'b1011 || o_length !== 12'hABC)
      $display("[TB] FAIL timeout_fields: got %b/%0d expected 1011/%0d", o_rate, o_length, 12'hABC);
    else passed++;
    tick();
    total++;
    if (o_sig_err !== 1'b0) $display("[TB] FAIL timeout_pulse_width: got %b expected 0", o_sig_err);
    else passed++;
  endtask

  task automatic test_abort();
    logic [95:0] bits;
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b0);
    run_emit(0, 15, 1'b0);
    for (int i = 0; i < 96; i++) bits[i] = 1'($urandom());
    drive_frame(bits, 1'b1);
    run_emit(0, -1, 1'b1);
    run_decode(make_dec(4'b1111, 12'd1500, 1'b0), 1'b1, 4'b1111, 12'd1500);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    i_rst     = 1'b0;
    i_abort   = 1'b0;
    i_di      = 1'b0;
    i_di_vld  = 1'b0;
    i_cw_rdy  = 1'b0;
    i_dec_bit = 1'b0;
    i_dec_vld = 1'b0;
    #1;
    $display("[TB] reset");
    test_reset();
    $display("[TB] nominal frame");
    test_nominal();
    $display("[TB] backpressure");
    test_backpressure();
    $display("[TB] bad fields");
    test_bad_field();
    $display("[TB] decode timeout");
    test_timeout();
    $display("[TB] abort during emit");
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
